fetch_stage: RTL and testbench

//   IF stage of the five-stage pipeline. Owns the 32-bit PC, drives the instruction-memory

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if_id_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_pkg
// Brief   : Shared types and constants for the IF stage (state encoding, NOP).
// Revision: 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int          c_pc_w    = 32;
    localparam int          c_imm_bit = 6;
    localparam logic [15:0] c_nop     = 16'h0000;

    typedef enum logic [1:0] {
        ST_RST_HI    = 2'd0,
        ST_RST_LO    = 2'd1,
        ST_FETCH     = 2'd2,
        ST_FETCH_IMM = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_if_id_reg
// Brief   : IF/ID pipeline register with load, clear-to-bubble and hold.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] NOP = c_nop
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [15:0]       i_instr,
    input  logic [15:0]       i_imm,
    input  logic [c_pc_w-1:0] i_pc,
    output logic              o_valid,
    output logic [15:0]       o_instr,
    output logic [15:0]       o_imm,
    output logic [c_pc_w-1:0] o_pc
);

    logic              r_valid;
    logic [15:0]       r_instr;
    logic [15:0]       r_imm;
    logic [c_pc_w-1:0] r_pc;

    // Clear wins over load; a bubble keeps the last pc since decode ignores it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_instr <= NOP;
            r_imm   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_imm   <= i_imm;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_imm   = r_imm;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : IF stage: PC, start-PC load, one/two-word assembly, IF/ID register.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          IM_AW   = 21,
    parameter int          IMM_BIT = c_imm_bit,
    parameter logic [15:0] NOP     = c_nop
) (
    input  logic              clk,
    input  logic              reset,
    output logic [IM_AW-1:0]  im_addr,
    input  logic [15:0]       im_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_en,
    input  logic [c_pc_w-1:0] redirect_pc,
    output logic              if_id_valid,
    output logic [15:0]       if_id_instr,
    output logic [15:0]       if_id_imm,
    output logic [c_pc_w-1:0] if_id_pc
);

    fetch_state_t      r_state;
    logic [c_pc_w-1:0] r_pc;
    logic [15:0]       r_ibuf;

    logic [c_pc_w-1:0] w_pc_inc;
    logic              w_fetching;
    logic              w_is_imm;
    logic              w_advance;
    logic              w_ifid_clear;
    logic              w_ifid_load;
    logic [15:0]       w_ifid_instr;
    logic [15:0]       w_ifid_imm;

    assign w_pc_inc   = r_pc + 32'd1;
    assign w_fetching = (r_state == ST_FETCH) || (r_state == ST_FETCH_IMM);
    assign w_is_imm   = im_data[IMM_BIT];
    assign w_advance  = w_fetching && !redirect_en && !flush && !stall;

    always_comb begin
        im_addr = r_pc[IM_AW-1:0];
        case (r_state)
            ST_RST_HI: im_addr = '0;
            ST_RST_LO: im_addr = IM_AW'(1);
            default:   im_addr = r_pc[IM_AW-1:0];
        endcase
    end

    // The first word of a two-word instruction leaves a bubble behind it.
    assign w_ifid_clear = !w_fetching || redirect_en || flush
                          || (w_advance && (r_state == ST_FETCH) && w_is_imm);
    assign w_ifid_load  = w_advance;
    assign w_ifid_instr = (r_state == ST_FETCH_IMM) ? r_ibuf  : im_data;
    assign w_ifid_imm   = (r_state == ST_FETCH_IMM) ? im_data : 16'h0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RST_HI;
            r_pc    <= '0;
            r_ibuf  <= '0;
        end else begin
            case (r_state)
                ST_RST_HI: begin
                    r_pc[31:16] <= im_data;
                    r_state     <= ST_RST_LO;
                end
                ST_RST_LO: begin
                    r_pc[15:0] <= im_data;
                    r_state    <= ST_FETCH;
                end
                ST_FETCH, ST_FETCH_IMM: begin
                    if (redirect_en) begin
                        r_pc    <= redirect_pc;
                        r_state <= ST_FETCH;
                        r_ibuf  <= '0;
                    end else if (w_advance) begin
                        r_pc <= w_pc_inc;
                        if (r_state == ST_FETCH_IMM) begin
                            r_state <= ST_FETCH;
                        end else if (w_is_imm) begin
                            r_ibuf  <= im_data;
                            r_state <= ST_FETCH_IMM;
                        end
                    end
                end
                default: r_state <= ST_RST_HI;
            endcase
        end
    end

    fetch_stage_if_id_reg #(
        .NOP (NOP)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_ifid_load),
        .i_clear (w_ifid_clear),
        .i_instr (w_ifid_instr),
        .i_imm   (w_ifid_imm),
        .i_pc    (w_pc_inc),
        .o_valid (if_id_valid),
        .o_instr (if_id_instr),
        .o_imm   (if_id_imm),
        .o_pc    (if_id_pc)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed self-checking bench for fetch_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [20:0] im_addr;
    logic [15:0] im_data;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_imm;
    logic [31:0] if_id_pc;

    logic [15:0] mem [0:511];
    int          checks;
    int          errors;

    assign im_data = mem[im_addr[8:0]];

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .stall       (stall),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_imm   (if_id_imm),
        .if_id_pc    (if_id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [15:0] ins,
                              input logic [15:0] imm, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
        check({tag, ".instr"}, {16'd0, if_id_instr}, {16'd0, ins});
        check({tag, ".imm"},   {16'd0, if_id_imm},   {16'd0, imm});
        check({tag, ".pc"},    if_id_pc,             pc);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[0]     = 16'h0000;
        mem[1]     = 16'h0020;
        mem[9'h20] = 16'h1001;
        mem[9'h21] = 16'h2002;
        mem[9'h22] = 16'h3003;

        // Reset state and two-cycle start-PC load
        repeat (2) tick();
        check_ifid("reset", 1'b0, 16'h0000, 16'h0000, 32'h0);
        check("reset.im_addr", {11'd0, im_addr}, 32'h0);
        reset = 1'b0;
        check("rst_hi.im_addr", {11'd0, im_addr}, 32'h0);
        tick();
        check("rst_lo.im_addr", {11'd0, im_addr}, 32'h1);
        check("rst_lo.valid", {31'd0, if_id_valid}, 32'h0);
        tick();
        check("start.im_addr", {11'd0, im_addr}, 32'h20);
        check("start.valid", {31'd0, if_id_valid}, 32'h0);

        // One-word stream
        tick();
        check_ifid("streamA", 1'b1, 16'h1001, 16'h0000, 32'h21);
        tick();
        check_ifid("streamB", 1'b1, 16'h2002, 16'h0000, 32'h22);
        tick();
        check_ifid("streamC", 1'b1, 16'h3003, 16'h0000, 32'h23);
        check("streamC.im_addr", {11'd0, im_addr}, 32'h23);

        // Two-word instruction via redirect back to 0x20
        mem[9'h20]  = 16'h4041;
        mem[9'h21]  = 16'hBEEF;
        mem[9'h22]  = 16'h5040;
        mem[9'h23]  = 16'hCAFE;
        mem[9'h24]  = 16'h6040;
        mem[9'h25]  = 16'h1234;
        mem[9'h100] = 16'h7007;
        mem[9'h101] = 16'h7107;
        mem[9'h1FF] = 16'h8008;
        redirect_en = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect_en = 1'b0;
        check_ifid("redir20", 1'b0, 16'h0000, 16'h0000, 32'h23);
        check("redir20.im_addr", {11'd0, im_addr}, 32'h20);
        tick();
        check("imm1.valid", {31'd0, if_id_valid}, 32'h0);
        check("imm1.im_addr", {11'd0, im_addr}, 32'h21);
        tick();
        check_ifid("imm2", 1'b1, 16'h4041, 16'hBEEF, 32'h22);

        // Stall three cycles in FETCH_IMM
        tick();
        check("pre_stall.valid", {31'd0, if_id_valid}, 32'h0);
        check("pre_stall.im_addr", {11'd0, im_addr}, 32'h23);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall.im_addr", {11'd0, im_addr}, 32'h23);
            check_ifid("stall", 1'b0, 16'h0000, 16'h0000, 32'h22);
        end
        stall = 1'b0;
        tick();
        check_ifid("post_stall", 1'b1, 16'h5040, 16'hCAFE, 32'h24);

        // Redirect together with stall in FETCH_IMM drops the buffer
        tick();
        check("pre_redir.im_addr", {11'd0, im_addr}, 32'h25);
        stall       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        tick();
        stall       = 1'b0;
        redirect_en = 1'b0;
        check("redir100.im_addr", {11'd0, im_addr}, 32'h100);
        check_ifid("redir100", 1'b0, 16'h0000, 16'h0000, 32'h24);
        tick();
        check_ifid("after_redir", 1'b1, 16'h7007, 16'h0000, 32'h101);

        // Flush refetches the current word
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.valid", {31'd0, if_id_valid}, 32'h0);
        check("flush.im_addr", {11'd0, im_addr}, 32'h101);
        tick();
        check_ifid("after_flush", 1'b1, 16'h7107, 16'h0000, 32'h102);

        // PC wrap at 0xFFFF_FFFF
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_en = 1'b0;
        check("wrap.im_addr", {11'd0, im_addr}, 32'h001F_FFFF);
        tick();
        check_ifid("wrap", 1'b1, 16'h8008, 16'h0000, 32'h0);
        check("wrap.next_addr", {11'd0, im_addr}, 32'h0);
        tick();
        check_ifid("post_wrap", 1'b1, 16'h0000, 16'h0000, 32'h1);

        // Asynchronous reset away from a clock edge
        #3;
        reset = 1'b1;
        #1;
        check_ifid("async_rst", 1'b0, 16'h0000, 16'h0000, 32'h0);
        check("async_rst.im_addr", {11'd0, im_addr}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
